// File: rtl/alarm_bank.sv
// Purpose : bank of N_ALARM wake alarms with snooze, ring timeout, do-not-disturb and sticky missed flags.
// Latency : ring rises one cycle after the matching sec_tick; writes and requests take effect at the next edge.
// Backpr. : none; every strobe is consumed in the cycle it arrives, and rejected writes are reported on wr_err.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   sec_tick                   one-cycle pulse per second; hour/minute/second/week already valid that cycle
//   hour, minute, second, week current time (week 0 = Sunday)
//   quiet                      do-not-disturb level
//   wr_en, wr_idx, wr_hour,
//   wr_min, wr_days, wr_on     slot programming strobe and payload
//   stop, snooze               one-cycle user requests
//   ring, ring_idx, snoozing   tone enable, active slot, snooze indication
//   missed                     sticky per-slot missed flags
//   wr_err                     one-cycle pulse for a rejected write
module alarm_bank #(
  parameter int N_ALARM    = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_SEC   = 60,
  parameter int IW         = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sec_tick,
  input  logic [4:0]         hour,
  input  logic [5:0]         minute,
  input  logic [5:0]         second,
  input  logic [2:0]         week,
  input  logic               quiet,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_idx,
  input  logic [4:0]         wr_hour,
  input  logic [5:0]         wr_min,
  input  logic [6:0]         wr_days,
  input  logic               wr_on,
  input  logic               stop,
  input  logic               snooze,
  output logic               ring,
  output logic [IW-1:0]      ring_idx,
  output logic               snoozing,
  output logic [N_ALARM-1:0] missed,
  output logic               wr_err
);

  localparam int WW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam int SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [WW-1:0] WAIT_LOAD = WW'(SNOOZE_MIN * 60);
  localparam logic [WW-1:0] WAIT_LAST = WW'(1);
  localparam logic [SW-1:0] SNZ_MAX   = SW'(MAX_SNOOZE);
  localparam logic [7:0]    RING_LAST = 8'(RING_SEC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  // slot storage
  logic [4:0]         alm_hour [N_ALARM];
  logic [5:0]         alm_min  [N_ALARM];
  logic [6:0]         alm_days [N_ALARM];
  logic [N_ALARM-1:0] alm_on;

  // FSM and counters
  state_t             state_q, state_d;
  logic [IW-1:0]      ring_idx_q, ring_idx_d;
  logic [7:0]         ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]      snz_cnt_q, snz_cnt_d;
  logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [N_ALARM-1:0] missed_q, missed_d;
  logic               quiet_q;
  logic               wr_err_q;

  logic               idx_ok;
  logic               wr_ok;
  logic               quiet_rise;
  logic [N_ALARM-1:0] match;
  logic               win_vld;
  logic [IW-1:0]      win_idx;

  // Index range check only exists when the index field can encode missing slots.
  generate
    if ((1 << IW) > N_ALARM) begin : g_idx_chk
      assign idx_ok = (wr_idx < IW'(N_ALARM));
    end else begin : g_idx_full
      assign idx_ok = 1'b1;
    end
  endgenerate

  assign wr_ok      = wr_en & idx_ok & (wr_hour <= 5'd23) & (wr_min <= 6'd59);
  assign quiet_rise = quiet & ~quiet_q;

  always_comb begin
    match = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      match[i] = sec_tick && (second == 6'd0) && alm_on[i] && alm_days[i][week] &&
                 (hour == alm_hour[i]) && (minute == alm_min[i]);
    end
  end

  // Lowest matching index wins; scan downwards so the last hit kept is the lowest.
  always_comb begin
    win_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (match[i]) begin
        win_idx = IW'(i);
      end
    end
  end

  assign win_vld = |match;

  always_comb begin
    state_d    = state_q;
    ring_idx_d = ring_idx_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    wait_cnt_d = wait_cnt_q;
    missed_d   = missed_q;

    case (state_q)
      IDLE: begin
        missed_d = missed_q | match;
        if (win_vld && !quiet) begin
          // the winner rings rather than being missed
          missed_d[win_idx] = missed_q[win_idx];
          state_d    = RINGING;
          ring_idx_d = win_idx;
          ring_cnt_d = '0;
          snz_cnt_d  = '0;
        end
      end

      RINGING: begin
        missed_d = missed_q | match;
        if (stop) begin
          state_d = IDLE;
        end else if (quiet_rise) begin
          state_d = IDLE;
        end else if (snooze) begin
          if (snz_cnt_q < SNZ_MAX) begin
            state_d    = SNOOZE;
            snz_cnt_d  = snz_cnt_q + SW'(1);
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else if (sec_tick) begin
          if (ring_cnt_q == RING_LAST) begin
            // nobody answered: auto-stop and remember it
            state_d              = IDLE;
            missed_d[ring_idx_q] = 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
      end

      SNOOZE: begin
        missed_d = missed_q | match;
        if (stop || quiet) begin
          state_d = IDLE;
        end else if (sec_tick) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q - WW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Reprogramming a slot overrides everything else for that slot,
    // including an auto-stop missed flag raised in the same cycle.
    if (wr_ok) begin
      missed_d[wr_idx] = 1'b0;
      if ((state_q != IDLE) && (wr_idx == ring_idx_q)) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ring_idx_q <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      wait_cnt_q <= '0;
      missed_q   <= '0;
      quiet_q    <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_idx_q <= ring_idx_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      missed_q   <= missed_d;
      quiet_q    <= quiet;
      wr_err_q   <= wr_en & ~wr_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ALARM; i++) begin
        alm_hour[i] <= '0;
        alm_min[i]  <= '0;
        alm_days[i] <= '0;
      end
      alm_on <= '0;
    end else if (wr_ok) begin
      alm_hour[wr_idx] <= wr_hour;
      alm_min[wr_idx]  <= wr_min;
      alm_days[wr_idx] <= wr_days;
      alm_on[wr_idx]   <= wr_on;
    end
  end

  // all outputs come straight from registers
  assign ring     = (state_q == RINGING);
  assign snoozing = (state_q == SNOOZE);
  assign ring_idx = ring_idx_q;
  assign missed   = missed_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_alarm_bank.sv
module tb_alarm_bank;

  localparam int N    = 4;
  localparam int SNZ  = 5;
  localparam int MAXS = 3;
  localparam int RSEC = 60;
  localparam int IW   = 2;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          sec_tick = 1'b0;
  logic [4:0]    hour     = '0;
  logic [5:0]    minute   = '0;
  logic [5:0]    second   = '0;
  logic [2:0]    week     = '0;
  logic          quiet    = 1'b0;
  logic          wr_en    = 1'b0;
  logic [IW-1:0] wr_idx   = '0;
  logic [4:0]    wr_hour  = '0;
  logic [5:0]    wr_min   = '0;
  logic [6:0]    wr_days  = '0;
  logic          wr_on    = 1'b0;
  logic          stop     = 1'b0;
  logic          snooze   = 1'b0;
  logic          ring;
  logic [IW-1:0] ring_idx;
  logic          snoozing;
  logic [N-1:0]  missed;
  logic          wr_err;

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  // current wall-clock time driven to the DUT
  int th = 0, tm = 0, ts = 0, tw = 0;

  always #5 clk = ~clk;

  alarm_bank #(
    .N_ALARM   (N),
    .SNOOZE_MIN(SNZ),
    .MAX_SNOOZE(MAXS),
    .RING_SEC  (RSEC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sec_tick (sec_tick),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .week     (week),
    .quiet    (quiet),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_hour  (wr_hour),
    .wr_min   (wr_min),
    .wr_days  (wr_days),
    .wr_on    (wr_on),
    .stop     (stop),
    .snooze   (snooze),
    .ring     (ring),
    .ring_idx (ring_idx),
    .snoozing (snoozing),
    .missed   (missed),
    .wr_err   (wr_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: a ring event is described by absolute deadlines in
  // elapsed seconds (tick_no) rather than by per-state counters.
  // mode: 0 idle, 1 ringing, 2 snoozed.
  // ---------------------------------------------------------------------
  int          m_h [N];
  int          m_m [N];
  logic [6:0]  m_d [N];
  bit          m_on[N];
  int          m_mode, m_idx, m_snz, tick_no, m_ring_end, m_wake, m_win;
  bit [N-1:0]  m_missed, m_hit;
  bit          m_err, m_qprev, m_wok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_h[i] = 0; m_m[i] = 0; m_d[i] = '0; m_on[i] = 1'b0;
      end
      m_mode = 0; m_idx = 0; m_snz = 0; tick_no = 0;
      m_ring_end = 0; m_wake = 0;
      m_missed = '0; m_err = 1'b0; m_qprev = 1'b0;
    end else begin
      if (sec_tick) tick_no++;
      m_hit = '0;
      m_win = -1;
      for (int i = 0; i < N; i++) begin
        if (sec_tick && second == 0 && m_on[i] && m_d[i][week] &&
            int'(hour) == m_h[i] && int'(minute) == m_m[i]) begin
          m_hit[i] = 1'b1;
          if (m_win < 0) m_win = i;
        end
      end
      m_wok = wr_en && wr_hour <= 23 && wr_min <= 59 && int'(wr_idx) < N;

      if (m_mode == 0) begin
        if (m_win >= 0 && !quiet) begin
          m_hit[m_win] = 1'b0;
          m_missed     = m_missed | m_hit;
          m_mode       = 1;
          m_idx        = m_win;
          m_snz        = 0;
          m_ring_end   = tick_no + RSEC;
        end else begin
          m_missed = m_missed | m_hit;
        end
      end else begin
        m_missed = m_missed | m_hit;
        if (m_wok && int'(wr_idx) == m_idx) m_mode = 0;
        else if (stop) m_mode = 0;
        else if (m_mode == 1) begin
          if (quiet && !m_qprev) m_mode = 0;
          else if (snooze) begin
            if (m_snz < MAXS) begin
              m_snz++;
              m_mode = 2;
              m_wake = tick_no + SNZ * 60;
            end else begin
              m_mode = 0;
            end
          end else if (sec_tick && tick_no == m_ring_end) begin
            m_mode = 0;
            m_missed[m_idx] = 1'b1;
          end
        end else begin
          if (quiet) m_mode = 0;
          else if (sec_tick && tick_no == m_wake) begin
            m_mode     = 1;
            m_ring_end = tick_no + RSEC;
          end
        end
      end

      if (m_wok) begin
        m_h[wr_idx]  = int'(wr_hour);
        m_m[wr_idx]  = int'(wr_min);
        m_d[wr_idx]  = wr_days;
        m_on[wr_idx] = wr_on;
        m_missed[wr_idx] = 1'b0;
      end
      m_err   = wr_en && !m_wok;
      m_qprev = quiet;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("ring",     int'(ring),     int'(m_mode == 1));
      chk("snoozing", int'(snoozing), int'(m_mode == 2));
      chk("missed",   int'(missed),   int'(m_missed));
      chk("wr_err",   int'(wr_err),   int'(m_err));
      if (m_mode != 0) chk("ring_idx", int'(ring_idx), m_idx);
    end
  end

  // ---------------------------------------------------------------------
  // stimulus helpers: inputs change on the falling edge only
  // ---------------------------------------------------------------------
  task automatic clr();
    sec_tick = 1'b0; wr_en = 1'b0; stop = 1'b0; snooze = 1'b0;
  endtask

  task automatic drive_time();
    hour = 5'(th); minute = 6'(tm); second = 6'(ts); week = 3'(tw);
  endtask

  task automatic set_time(input int h, input int m, input int s, input int w);
    @(negedge clk); clr();
    th = h; tm = m; ts = s; tw = w;
    drive_time();
  endtask

  task automatic tick();
    @(negedge clk); clr();
    ts++;
    if (ts == 60) begin ts = 0; tm++; end
    if (tm == 60) begin tm = 0; th++; end
    if (th == 24) begin th = 0; tw = (tw + 1) % 7; end
    drive_time();
    sec_tick = 1'b1;
    @(negedge clk); clr();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input int idx, input int h, input int m, input logic [6:0] d, input bit on);
    @(negedge clk); clr();
    wr_idx = IW'(idx); wr_hour = 5'(h); wr_min = 6'(m); wr_days = d; wr_on = on;
    wr_en = 1'b1;
    @(negedge clk); clr();
  endtask

  task automatic pulse(input bit st, input bit sn);
    @(negedge clk); clr();
    stop = st; snooze = sn;
    @(negedge clk); clr();
  endtask

  task automatic set_quiet(input bit v);
    @(negedge clk); clr();
    quiet = v;
    @(negedge clk); clr();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ring",   int'(ring),     0);
    chk("rst_snz",    int'(snoozing), 0);
    chk("rst_missed", int'(missed),   0);
    chk("rst_err",    int'(wr_err),   0);
    chk("rst_idx",    int'(ring_idx), 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // basic ring and auto-stop after RING_SEC ticks
    wr(1, 7, 30, 7'h7F, 1'b1);
    set_time(7, 29, 59, 3);
    tick();
    chk("t1_ring", int'(ring), 1);
    chk("t1_idx",  int'(ring_idx), 1);
    ticks(RSEC - 1);
    chk("t1_ring_last", int'(ring), 1);
    tick();
    chk("t1_autostop", int'(ring), 0);
    chk("t1_missed1",  int'(missed[1]), 1);

    // snooze up to the limit, the next snooze stops
    wr(0, 8, 0, 7'h7F, 1'b1);
    set_time(7, 59, 59, 3);
    tick();
    chk("t2_ring", int'(ring), 1);
    chk("t2_idx",  int'(ring_idx), 0);
    for (int k = 0; k < MAXS; k++) begin
      pulse(1'b0, 1'b1);
      chk("t2_snoozing", int'(snoozing), 1);
      chk("t2_ring_off", int'(ring), 0);
      ticks(SNZ * 60 - 1);
      chk("t2_still_snoozing", int'(snoozing), 1);
      tick();
      chk("t2_rering", int'(ring), 1);
    end
    pulse(1'b0, 1'b1);
    chk("t2_limit_ring",  int'(ring), 0);
    chk("t2_limit_snz",   int'(snoozing), 0);
    chk("t2_no_missed0",  int'(missed[0]), 0);

    // two slots at the same time: lowest wins, the other is missed
    wr(0, 6, 0, 7'h7F, 1'b1);
    wr(2, 6, 0, 7'h7F, 1'b1);
    set_time(5, 59, 59, 3);
    tick();
    chk("t3_ring",    int'(ring), 1);
    chk("t3_idx",     int'(ring_idx), 0);
    chk("t3_missed2", int'(missed[2]), 1);
    pulse(1'b1, 1'b1);                 // stop and snooze together
    chk("t3_stopwins_ring", int'(ring), 0);
    chk("t3_stopwins_snz",  int'(snoozing), 0);
    wr(2, 6, 0, 7'h7F, 1'b1);
    chk("t3_clr_missed2", int'(missed[2]), 0);
    chk("t3_keep_missed1", int'(missed[1]), 1);

    // do-not-disturb
    set_quiet(1'b1);
    wr(3, 9, 0, 7'h7F, 1'b1);
    set_time(8, 59, 59, 3);
    tick();
    chk("t4_quiet_ring",   int'(ring), 0);
    chk("t4_quiet_missed", int'(missed[3]), 1);
    set_quiet(1'b0);
    wr(3, 9, 5, 7'h7F, 1'b1);
    chk("t4_clr_missed3", int'(missed[3]), 0);
    set_time(9, 4, 59, 3);
    tick();
    chk("t4_ring", int'(ring), 1);
    chk("t4_idx",  int'(ring_idx), 3);
    set_quiet(1'b1);
    chk("t4_quiet_stop",  int'(ring), 0);
    chk("t4_no_missed3",  int'(missed[3]), 0);
    set_quiet(1'b0);

    // weekday mask, rewrite of the active slot, rejected writes
    wr(2, 10, 0, 7'b0000010, 1'b1);
    set_time(9, 59, 59, 2);
    tick();
    chk("t5_wrong_day", int'(ring), 0);
    chk("t5_wrong_day_missed", int'(missed[2]), 0);
    set_time(9, 59, 59, 1);
    tick();
    chk("t5_monday_ring", int'(ring), 1);
    chk("t5_monday_idx",  int'(ring_idx), 2);
    wr(2, 10, 0, 7'b0000010, 1'b1);
    chk("t5_rewrite_stop", int'(ring), 0);
    wr(2, 24, 0, 7'b0000010, 1'b1);
    chk("t5_err_hour", int'(wr_err), 1);
    @(negedge clk); clr();
    chk("t5_err_pulse", int'(wr_err), 0);
    wr(2, 11, 60, 7'b0000010, 1'b1);
    chk("t5_err_min", int'(wr_err), 1);
    set_time(9, 59, 59, 1);
    tick();
    chk("t5_unchanged_ring", int'(ring), 1);
    chk("t5_unchanged_idx",  int'(ring_idx), 2);

    // asynchronous reset in the middle of a ring
    ticks(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ring", int'(ring), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_time(9, 59, 59, 1);
    tick();
    chk("t6_slot2_off", int'(ring), 0);
    set_time(7, 29, 59, 3);
    tick();
    chk("t6_slot1_off", int'(ring), 0);
    chk("t6_missed",    int'(missed), 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Parametrised successor of the single alarm: N independent alarm slots, each with hour/minute, weekday repeat mask and enable.
- Adds snooze with a configurable interval and limit, auto-stop on ring timeout, do-not-disturb suppression, and sticky missed-alarm flags.
- Sits between the current-time counter and the music/wake-tone path. The `ring` output drives the tone start, the same way the old alarm's `do` did.
- Display and edit UI stay outside this block; they program slots over a simple write port.

Parameters:
- N_ALARM, 4, number of alarm slots (1..8).
- SNOOZE_MIN, 5, snooze interval in minutes (1..30).
- MAX_SNOOZE, 3, snoozes allowed per ring event. A snooze request beyond this acts as stop.
- RING_SEC, 60, ring duration in seconds before auto-stop (1..255).
- IW, $clog2(N_ALARM) (minimum 1), slot index width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle pulse per second; time inputs are already updated in the same cycle
- hour  in  5  current hour 0..23
- minute  in  6  current minute 0..59
- second  in  6  current second 0..59
- week  in  3  current weekday 0..6 (0 = Sunday)
- quiet  in  1  do-not-disturb switch, level
- wr_en  in  1  one-cycle slot write strobe
- wr_idx  in  IW  slot to write
- wr_hour  in  5  alarm hour
- wr_min  in  6  alarm minute
- wr_days  in  7  weekday repeat mask; bit d means ring on weekday d
- wr_on  in  1  slot enable
- stop  in  1  one-cycle stop request
- snooze  in  1  one-cycle snooze request
- ring  out  1  tone enable, high while RINGING
- ring_idx  out  IW  slot currently ringing or snoozing
- snoozing  out  1  high while in SNOOZE
- missed  out  N_ALARM  sticky per-slot missed flags
- wr_err  out  1  one-cycle pulse when a write is rejected

Behaviour:

Reset:
- All slots are cleared: hour 0, min 0, days 0, on 0.
- FSM goes to IDLE.
- ring, snoozing, ring_idx, missed and wr_err are all 0.
- Counters are 0.

Write:
- Registered on the wr_en cycle.
- If wr_hour > 23, wr_min > 59 or wr_idx >= N_ALARM, the slot is unchanged and wr_err pulses on the next cycle.
- A valid write clears missed[wr_idx].
- If wr_idx equals the active ring_idx in RINGING or SNOOZE, the FSM returns to IDLE next cycle.

Match for slot i:
- Condition: sec_tick & second==0 & on[i] & days[i][week] & hour==alm_hour[i] & minute==alm_min[i].
- When several slots match in the same tick, the lowest index wins. The other matching slots set their missed bits.

FSM states: IDLE, RINGING, SNOOZE.

IDLE:
- A match with quiet=0 moves to RINGING. ring_idx latches the winner, ring_cnt=0 and snooze_cnt=0.
- ring rises on the cycle after the matching sec_tick.
- A match with quiet=1 does not ring; it sets missed[i].

RINGING:
- ring_cnt increments on each sec_tick.
- stop moves to IDLE.
- snooze moves to SNOOZE if snooze_cnt < MAX_SNOOZE: snooze_cnt+1, wait_cnt loaded with SNOOZE_MIN*60.
- snooze when snooze_cnt == MAX_SNOOZE acts as stop.
- When ring_cnt reaches RING_SEC-1 and a sec_tick arrives, the FSM moves to IDLE and sets missed[ring_idx] (auto-stop).
- quiet rising moves to IDLE with no missed flag.

SNOOZE:
- wait_cnt decrements on each sec_tick.
- At a sec_tick with wait_cnt == 1, the FSM moves to RINGING with ring_cnt=0; ring_idx and snooze_cnt are kept.
- stop moves to IDLE.
- snooze is ignored.
- quiet=1 moves to IDLE.

Simultaneous events and priorities:
- A match while in RINGING or SNOOZE for any slot, including the active one, sets missed for that slot; the FSM state is unchanged.
- stop and snooze in the same cycle: stop wins.
- Event priority in a cycle: write-clear > stop > snooze > timeout/expiry.

Internal widths:
- wait_cnt width is $clog2(SNOOZE_MIN*60+1).
- ring_cnt is 8 bits.

Misc:
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-ring drops ring asynchronously.

Test Plan:
- Write slot 1 = 07:30, days=7'h7F, on; drive time 07:29:59 → 07:30:00 with sec_tick → ring=1 and ring_idx=1 the next cycle. After 60 ticks with no input, ring=0 and missed[1]=1.
- Ring slot 0, pulse snooze → snoozing=1, ring=0. After 300 sec_ticks ring=1 again. Repeat snooze 3 times, then a 4th snooze → IDLE, ring=0.
- Slots 0 and 2 both set to 06:00 → ring_idx=0 and missed[2]=1. Write slot 2 → missed[2]=0.
- quiet=1 at a slot 3 match time → ring stays 0 and missed[3]=1. With quiet=0, set quiet=1 during ringing → ring=0 and the missed bit stays 0.
- days=7'b0000010 (Monday only): at the alarm time with week=2 there is no ring; with week=1 it rings. Write wr_hour=24 → wr_err pulses and the slot is unchanged.
- Assert rst_n=0 mid-RINGING → ring=0 immediately. After release all slots are disabled, and time matches do not ring.
